// File: rtl/spi_slave_if.sv
// spi_slave_if: bundles the SPI pad signals and the core-side byte interface
// of spi_slave.
//   SCK, SS, MOSI : serial clock, active-low select and data from the master
//   MISO          : serial data back to the master
//   DATA          : byte to transmit (core side)
//   MODE          : {CPOL, CPHA}
//   OUT           : last complete received byte
//   DONE          : one-clk pulse when OUT updates
// Modports: slave (the spi_slave endpoint), master (pads plus core driver).
interface spi_slave_if;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned MODE_W = 2;

  logic              SCK;
  logic              SS;
  logic              MOSI;
  logic              MISO;
  logic [WORD_W-1:0] DATA;
  logic [MODE_W-1:0] MODE;
  logic [WORD_W-1:0] OUT;
  logic              DONE;

  modport slave (
    input  SCK, SS, MOSI, DATA, MODE,
    output MISO, OUT, DONE
  );

  modport master (
    output SCK, SS, MOSI, DATA, MODE,
    input  MISO, OUT, DONE
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave endpoint, 8-bit words, MSB first, all four
// SPI modes. SCK/SS/MOSI are synchronised into clk; every state change happens
// on clk. Multiple bytes per selection are supported.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : spi_slave_if.slave (SCK, SS, MOSI in; MISO out; DATA, MODE in;
//          OUT, DONE out)
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,  // after reset: wait for a settled SS high
    ST_IDLE,       // deselected: wait for SS fall
    ST_ACTIVE      // selected: process SCK edges
  } state_t;

  // Synchroniser and edge-detect registers
  logic sck_s1, sck_s2, sck_s3;
  logic ss_s1, ss_s2, ss_s3;
  logic mosi_s1, mosi_s2;

  // Datapath and control state
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   tx_q, tx_d;
  logic [WORD_W-1:0]   rx_q, rx_d;
  logic [WORD_W-1:0]   out_q, out_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                miso_q, miso_d;
  logic                done_q, done_d;

  // Edge strobes derived from the synchronised pins
  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cpol, cpha;

  // Two-stage synchronisers plus a third stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_s3   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= bus.SCK;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      ss_s1   <= bus.SS;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      mosi_s1 <= bus.MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_s3;
  assign sck_fall = ~sck_s2 & sck_s3;
  assign ss_fall  = ~ss_s2 & ss_s3;
  assign ss_rise  = ss_s2 & ~ss_s3;

  // Mode is taken from the latch, stable for the whole selection
  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign lead_edge   = cpol ? sck_fall : sck_rise;
  assign trail_edge  = cpol ? sck_rise : sck_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      out_q   <= '0;
      mode_q  <= '0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    out_d   = out_q;
    mode_d  = mode_q;
    miso_d  = miso_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_WAIT_IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (ss_s2) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = ST_ACTIVE;
          mode_d  = bus.MODE;
          // CPHA=0 must present bit 7 before the first leading edge
          if (!bus.MODE[0]) begin
            tx_d   = bus.DATA;
            miso_d = bus.DATA[WORD_W-1];
          end
        end
      end

      ST_ACTIVE: begin
        if (sample_edge) begin
          rx_d = {rx_q[WORD_W-2:0], mosi_s2};
          if (cnt_q == CNT_W'(WORD_W - 1)) begin
            cnt_d  = '0;
            out_d  = {rx_q[WORD_W-2:0], mosi_s2};
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        if (shift_edge) begin
          if (!cpha) begin
            // Counter at zero here means a byte just finished: fetch the next
            if (cnt_q != '0) begin
              tx_d   = tx_q << 1;
              miso_d = tx_q[WORD_W-2];
            end else begin
              tx_d   = bus.DATA;
              miso_d = bus.DATA[WORD_W-1];
            end
          end else begin
            if (cnt_q == '0) begin
              tx_d   = bus.DATA << 1;
              miso_d = bus.DATA[WORD_W-1];
            end else begin
              tx_d   = tx_q << 1;
              miso_d = tx_q[WORD_W-1];
            end
          end
        end

        // Deselect drops any partial byte; a byte completing this cycle stands
        if (ss_rise) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_WAIT_IDLE;
      end
    endcase
  end

  assign bus.MISO = miso_q;
  assign bus.OUT  = out_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave. A table of single-byte
// selections across all modes, plus sequences for back-to-back bytes,
// mid-byte deselect and mid-byte reset.
module tb_spi_slave;
  logic clk;
  logic rst;
  spi_slave_if bus ();

  spi_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_vec;
  int n_bad;
  int done_cnt;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] mosi;
    logic [7:0] data;
    logic [7:0] exp_out;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [8];

  // DONE pulses are counted away from the active edge
  always @(negedge clk) begin
    if (!rst && bus.DONE) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  task automatic half_sck();
    repeat (6) @(negedge clk);
  endtask

  task automatic select(input logic [1:0] m, input logic [7:0] d);
    bus.MODE = m;
    bus.DATA = d;
    bus.SCK  = m[1];
    half_sck();
    bus.SS = 1'b0;
    half_sck();
  endtask

  task automatic deselect();
    half_sck();
    bus.SS = 1'b1;
    half_sck();
  endtask

  // Master side of nbits SCK cycles, MSB first
  task automatic xfer(input logic [1:0] m, input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!m[0]) begin
        bus.MOSI = tx[i];
        half_sck();
        rx[i]   = bus.MISO;
        bus.SCK = ~m[1];
        half_sck();
        bus.SCK = m[1];
      end else begin
        bus.SCK  = ~m[1];
        bus.MOSI = tx[i];
        half_sck();
        rx[i]   = bus.MISO;
        bus.SCK = m[1];
        half_sck();
      end
    end
  endtask

  initial begin
    logic [7:0] rx;
    int d0;

    vecs[0] = '{2'd0, 8'hA5, 8'hB1, 8'hA5, 8'hB1};
    vecs[1] = '{2'd0, 8'h3C, 8'h1F, 8'h3C, 8'h1F};
    vecs[2] = '{2'd0, 8'hF0, 8'hEA, 8'hF0, 8'hEA};
    vecs[3] = '{2'd1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[4] = '{2'd2, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[5] = '{2'd3, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[6] = '{2'd1, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[7] = '{2'd3, 8'h00, 8'hFF, 8'h00, 8'hFF};

    n_vec    = 0;
    n_bad    = 0;
    done_cnt = 0;
    rst      = 1'b1;
    bus.SCK  = 1'b0;
    bus.SS   = 1'b1;
    bus.MOSI = 1'b0;
    bus.DATA = 8'h00;
    bus.MODE = 2'd0;
    repeat (4) @(negedge clk);
    chk("reset OUT", bus.OUT, 8'h00);
    chk("reset MISO", {7'd0, bus.MISO}, 8'h00);
    chk("reset DONE", {7'd0, bus.DONE}, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single-byte selections from the table
    for (int v = 0; v < 8; v++) begin
      select(vecs[v].mode, vecs[v].data);
      d0 = done_cnt;
      xfer(vecs[v].mode, vecs[v].mosi, 8, rx);
      deselect();
      chk($sformatf("vec%0d OUT", v), bus.OUT, vecs[v].exp_out);
      chk($sformatf("vec%0d master rx", v), rx, vecs[v].exp_miso);
      chk($sformatf("vec%0d DONE pulses", v), 8'(done_cnt - d0), 8'd1);
    end

    // Two bytes in one selection, DATA swapped after the first byte
    select(2'd0, 8'hAB);
    d0 = done_cnt;
    xfer(2'd0, 8'h12, 8, rx);
    bus.DATA = 8'hCD;
    chk("b2b first master rx", rx, 8'hAB);
    repeat (3) @(negedge clk);
    chk("b2b first OUT", bus.OUT, 8'h12);
    xfer(2'd0, 8'h34, 8, rx);
    chk("b2b second master rx", rx, 8'hCD);
    deselect();
    chk("b2b second OUT", bus.OUT, 8'h34);
    chk("b2b DONE pulses", 8'(done_cnt - d0), 8'd2);

    // Deselect after 5 bits, then a full byte
    select(2'd0, 8'h0F);
    d0 = done_cnt;
    xfer(2'd0, 8'hE6, 5, rx);
    deselect();
    chk("abort OUT held", bus.OUT, 8'h34);
    chk("abort no DONE", 8'(done_cnt - d0), 8'd0);
    chk("abort MISO idle", {7'd0, bus.MISO}, 8'h00);
    select(2'd0, 8'h81);
    d0 = done_cnt;
    xfer(2'd0, 8'h77, 8, rx);
    deselect();
    chk("after abort OUT", bus.OUT, 8'h77);
    chk("after abort master rx", rx, 8'h81);
    chk("after abort DONE pulses", 8'(done_cnt - d0), 8'd1);

    // Reset mid-byte; bus ignored until SS returns high
    select(2'd0, 8'hFF);
    xfer(2'd0, 8'hC3, 4, rx);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst OUT", bus.OUT, 8'h00);
    chk("midrst MISO", {7'd0, bus.MISO}, 8'h00);
    chk("midrst DONE", {7'd0, bus.DONE}, 8'h00);
    rst = 1'b0;
    d0 = done_cnt;
    xfer(2'd0, 8'hFF, 8, rx);
    chk("post-rst ignored DONE", 8'(done_cnt - d0), 8'd0);
    chk("post-rst ignored OUT", bus.OUT, 8'h00);
    chk("post-rst ignored master rx", rx, 8'h00);
    deselect();
    select(2'd0, 8'h66);
    d0 = done_cnt;
    xfer(2'd0, 8'h99, 8, rx);
    deselect();
    chk("post-rst OUT", bus.OUT, 8'h99);
    chk("post-rst master rx", rx, 8'h66);
    chk("post-rst DONE pulses", 8'(done_cnt - d0), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
